// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - fetch PC sequencer with branch/jump redirect, flush and stats
//
// Purpose: drives the IF-stage PC. It advances by 4 each unstalled cycle, and it
// loads a resolved branch or jump target when EX requests a redirect. After a
// redirect it squashes the younger stages for FLUSH_CYCLES cycles. A redirect
// that arrives while fetch is stalled is parked until the stall clears.
//
// Ports:
//   Clk, Rst            clock (rising edge), synchronous active-low reset
//   stall               fetch stall, PC holds while high
//   br_valid/br_taken   conditional branch present / resolved taken
//   br_target           branch target
//   jmp_valid/jmp_target unconditional jump present / target (wins over branch)
//   pc, pc_plus4        current fetch PC and PC + 4
//   flush               squash IF/ID (registered)
//   redirect            one-cycle pulse aligned with a freshly loaded target
//   br_count            conditional branches resolved (saturating)
//   taken_count         conditional branches taken (saturating)
module branch_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp_valid,
    input  logic [31:0]      jmp_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             flush,
    output logic             redirect,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_q, pend_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic             flush_q, flush_d;
    logic             redirect_q, redirect_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

    logic             req;
    logic [31:0]      tgt_raw;
    logic [31:0]      tgt;
    logic [31:0]      pc_seq;

    assign req     = jmp_valid | (br_valid & br_taken);
    assign tgt_raw = jmp_valid ? jmp_target : br_target;
    assign tgt     = {tgt_raw[31:2], 2'b00};
    assign pc_seq  = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        fcnt_d     = fcnt_q;
        flush_d    = 1'b0;
        redirect_d = 1'b0;
        br_cnt_d   = br_cnt_q;
        tk_cnt_d   = tk_cnt_q;

        unique case (state_q)
            ST_RUN: begin
                if (br_valid && (br_cnt_q != CNT_MAX)) begin
                    br_cnt_d = br_cnt_q + CNT_ONE;
                end
                if (br_valid && br_taken && (tk_cnt_q != CNT_MAX)) begin
                    tk_cnt_d = tk_cnt_q + CNT_ONE;
                end
                if (req) begin
                    // Flush either way: the stalled younger instruction must die now.
                    flush_d = 1'b1;
                    if (!stall) begin
                        pc_d       = tgt;
                        redirect_d = 1'b1;
                        fcnt_d     = FLUSH_INIT;
                        state_d    = ST_FLUSH;
                    end else begin
                        pend_d  = tgt;
                        state_d = ST_PEND;
                    end
                end else if (!stall) begin
                    pc_d = pc_seq;
                end
            end
            ST_PEND: begin
                flush_d = 1'b1;
                if (!stall) begin
                    pc_d       = pend_q;
                    redirect_d = 1'b1;
                    fcnt_d     = FLUSH_INIT;
                    state_d    = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    pc_d = pc_seq;
                end
                // Counter runs regardless of stall; the last count drops flush.
                fcnt_d = fcnt_q - 3'd1;
                if (fcnt_q == 3'd1) begin
                    state_d = ST_RUN;
                end else begin
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pend_q     <= 32'd0;
            fcnt_q     <= 3'd0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            br_cnt_q   <= '0;
            tk_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            fcnt_q     <= fcnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            br_cnt_q   <= br_cnt_d;
            tk_cnt_q   <= tk_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_seq;
    assign flush       = flush_q;
    assign redirect    = redirect_q;
    assign br_count    = br_cnt_q;
    assign taken_count = tk_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb/tb_branch_redirect_unit.sv - self-checking bench for branch_redirect_unit
module tb_branch_redirect_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          FC     = 2;
    localparam int          CW     = 4;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          stall = 1'b0;
    logic          br_valid = 1'b0;
    logic          br_taken = 1'b0;
    logic [31:0]   br_target = 32'd0;
    logic          jmp_valid = 1'b0;
    logic [31:0]   jmp_target = 32'd0;
    logic [31:0]   pc;
    logic [31:0]   pc_plus4;
    logic          flush;
    logic          redirect;
    logic [CW-1:0] br_count;
    logic [CW-1:0] taken_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: PC value, a parked target, and how many flush cycles remain.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_pending;
    int          m_left;
    bit          m_redirect;
    int          m_br;
    int          m_tk;

    branch_redirect_unit #(
        .RESET_PC    (RST_PC),
        .FLUSH_CYCLES(FC),
        .CNT_W       (CW)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .flush      (flush),
        .redirect   (redirect),
        .br_count   (br_count),
        .taken_count(taken_count)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] t;
        m_redirect = 1'b0;
        if (!Rst) begin
            m_pc = RST_PC; m_pending = 1'b0; m_left = 0; m_br = 0; m_tk = 0;
        end else if (m_left > 0) begin
            if (!stall) m_pc = m_pc + 32'd4;
            m_left--;
        end else if (m_pending) begin
            if (!stall) begin
                m_pc = m_pend; m_redirect = 1'b1; m_left = FC; m_pending = 1'b0;
            end
        end else begin
            if (br_valid && m_br < CMAX) m_br++;
            if (br_valid && br_taken && m_tk < CMAX) m_tk++;
            t = jmp_valid ? jmp_target : br_target;
            t = t & 32'hFFFF_FFFC;
            if (jmp_valid || (br_valid && br_taken)) begin
                if (!stall) begin
                    m_pc = t; m_redirect = 1'b1; m_left = FC;
                end else begin
                    m_pend = t; m_pending = 1'b1;
                end
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("pc", pc, m_pc);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_eq("flush", {31'd0, flush}, {31'd0, (m_left > 0) || m_pending});
        check_eq("redirect", {31'd0, redirect}, {31'd0, m_redirect});
        check_eq("br_count", 32'(br_count), 32'(m_br));
        check_eq("taken_count", 32'(taken_count), 32'(m_tk));
    endtask

    task automatic drive(input logic r, input logic s, input logic bv, input logic bt,
                         input logic [31:0] btg, input logic jv, input logic [31:0] jtg);
        Rst = r; stall = s; br_valid = bv; br_taken = bt;
        br_target = btg; jmp_valid = jv; jmp_target = jtg;
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        compare_all();
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        m_pc = 32'd0; m_pend = 32'd0; m_pending = 1'b0; m_left = 0;
        m_redirect = 1'b0; m_br = 0; m_tk = 0;

        // Reset and sequential fetch
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("rst_pc", pc, RST_PC);
        check_eq("rst_flush", {31'd0, flush}, 32'd0);
        idle();
        idle();
        check_eq("seq_pc8", pc, 32'h8);

        // Taken branch at pc 0x8
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'd0);
        check_eq("br_pc", pc, 32'h100);
        check_eq("br_redirect", {31'd0, redirect}, 32'd1);
        idle();
        check_eq("br_pc104_flush", {31'd0, flush}, 32'd1);
        idle();
        check_eq("br_pc108", pc, 32'h108);
        check_eq("br_flush_done", {31'd0, flush}, 32'd0);

        // Not-taken branch
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 1'b0, 32'd0);
        check_eq("nt_pc", pc, 32'h10C);
        check_eq("nt_brcnt", 32'(br_count), 32'd2);
        check_eq("nt_tkcnt", 32'(taken_count), 32'd1);

        // Jump under stall, branch during PEND ignored
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h2003);
        check_eq("pend_flush", {31'd0, flush}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("pend_pc_hold", pc, 32'h10C);
        idle();
        check_eq("pend_release_pc", pc, 32'h2000);
        check_eq("pend_brcnt", 32'(br_count), 32'd2);
        idle();
        idle();

        // Jump and taken branch together: jump wins, branch counted
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40);
        check_eq("prio_pc", pc, 32'h40);
        check_eq("prio_tkcnt", 32'(taken_count), 32'd2);

        // Reset with one flush cycle left
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("midflush_rst_pc", pc, RST_PC);
        check_eq("midflush_rst_flush", {31'd0, flush}, 32'd0);
        check_eq("midflush_rst_cnt", 32'(br_count), 32'd0);

        // PC wrap
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF);
        check_eq("wrap_top", pc, 32'hFFFF_FFFC);
        check_eq("wrap_plus4", pc_plus4, 32'h0);
        idle();
        check_eq("wrap_pc0", pc, 32'h0);
        idle();

        // Counter saturation
        for (int i = 0; i < CMAX + 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        end
        check_eq("sat_brcnt", 32'(br_count), 32'(CMAX));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, bv, bt, jv;
            logic [31:0] bta, jta;
            r   = ($urandom_range(0, 99) >= 2);
            s   = ($urandom_range(0, 99) < 30);
            bv  = ($urandom_range(0, 99) < 45);
            bt  = $urandom_range(0, 1) == 1;
            jv  = ($urandom_range(0, 99) < 10);
            bta = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            jta = $urandom();
            drive(r, s, bv, bt, bta, jv, jta);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- PC sequencer sitting between the EX-stage branch condition evaluation and the IF stage.
- Consumes the resolved branch decision and target each cycle, then drives the fetch PC.
- On a taken branch or jump it redirects the PC and generates a multi-cycle flush of younger pipeline stages.
- Redirects that arrive while the fetch stage is stalled are held pending until the stall clears.
- Keeps saturating branch statistics counters for performance checks.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (1..7)
CNT_W, 16, width of the statistics counters

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  synchronous reset, active-low
stall  input  1  fetch stall; PC holds while high
br_valid  input  1  EX stage holds a conditional branch this cycle
br_taken  input  1  resolved condition from branch logic; qualified by br_valid
br_target  input  32  branch target address
jmp_valid  input  1  EX stage holds an unconditional jump
jmp_target  input  32  jump target address
pc  output  32  current fetch PC
pc_plus4  output  32  pc + 4, combinational from pc
flush  output  1  squash IF/ID contents
redirect  output  1  one-cycle pulse on the cycle pc is loaded with a target
br_count  output  CNT_W  conditional branches resolved
taken_count  output  CNT_W  conditional branches taken

Behaviour:
- Reset (Rst low at a rising edge) has the following effects:
  - pc = RESET_PC; flush = 0; redirect = 0; both counters = 0.
  - State goes to RUN; pending target is cleared.
  - Reset overrides every other input, including when asserted mid-flush or mid-pending.
- A redirect request is: (br_valid & br_taken) | jmp_valid.
- Priority: jmp_valid > branch. If both are valid in the same cycle, jmp_target wins. The branch is still counted.
- Next-PC arithmetic:
  - Sequential next PC is pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Target bits [1:0] are forced to 0 when loaded.
- State machine RUN / PEND / FLUSH:
  - RUN, redirect request, stall = 0:
    - pc <= target; redirect pulses for one cycle.
    - Flush counter is loaded with FLUSH_CYCLES.
    - Next state is FLUSH.
  - RUN, redirect request, stall = 1:
    - Target is latched into the pending register; pc holds.
    - Next state is PEND.
    - flush asserts immediately, so the stalled younger instruction is killed.
  - RUN, no request: pc <= pc + 4 if stall = 0, otherwise hold.
  - PEND:
    - pc holds and flush = 1. New redirect requests are ignored, because the pipeline is already being squashed.
    - When stall drops: pc <= pending target; redirect pulses.
    - Flush counter is loaded with FLUSH_CYCLES; next state is FLUSH.
  - FLUSH:
    - flush = 1; pc advances by +4 when stall = 0.
    - The counter decrements on every cycle, regardless of stall. The state returns to RUN when the counter reaches 1 and decrements.
    - Result: flush is high for exactly FLUSH_CYCLES cycles after the redirect edge.
    - br_valid and jmp_valid are ignored in FLUSH, since the instructions are squashed.
- flush and redirect are registered outputs (Moore style): redirect is high in the cycle after the request edge, aligned with the new pc.
- Counters:
  - br_count increments on br_valid in RUN only; taken_count increments on br_valid & br_taken in RUN only.
  - Both counters saturate at all-ones and never wrap.
- Latency: request at edge N gives pc = target visible after edge N, provided stall is low.

Test Plan:
- Reset then 4 cycles without stall: pc goes RESET_PC → +4 → +8 → +C → +10; flush = 0; counters = 0.
- br_valid = 1, br_taken = 1, br_target = 32'h0000_0100 at pc = 0x8, stall = 0:
  - Next cycle pc = 0x100, redirect = 1 for 1 cycle, flush = 1 for 2 cycles.
  - Then pc = 0x104, 0x108; br_count = 1, taken_count = 1.
- br_valid = 1, br_taken = 0: no redirect, flush stays 0, pc continues +4; br_count increments and taken_count does not.
- Stall held for 3 cycles, with jmp_valid = 1 and jmp_target = 0x2003 on the first stall cycle:
  - PEND state, pc holds, flush = 1.
  - On stall release pc = 0x2000 and redirect pulses.
  - A br_valid issued during PEND is ignored and not counted.
- Simultaneous jmp_valid with target 0x40 and taken branch with target 0x80: pc = 0x40; br_count and taken_count each +1.
- Rst low during FLUSH with the counter at 1 remaining: next cycle pc = RESET_PC, flush = 0, counters = 0. pc = 0xFFFF_FFFC with no stall wraps to 0x0.
